// File: rtl/branch_resolve_ctrl.sv
// rtl/branch_resolve_ctrl.sv - ID-stage conditional branch sequencing, redirect and statistics
module branch_resolve_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             br_valid,
  input  logic [2:0]       br_op,
  input  logic [31:0]      br_target,
  input  logic             opnd_ready,
  input  logic             ds_valid,
  input  logic             flush,
  input  logic             cmp_result,
  output logic [2:0]       cmp_op,
  output logic             id_stall,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             illegal_op,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT_OPND, WAIT_DS} state_t;

  state_t      state;
  logic [2:0]  held_op;
  logic [31:0] held_target;
  logic        in_idle;
  logic        in_wait_opnd;
  logic        op_legal;
  logic        resolve;
  logic [31:0] cur_target;

  always_comb begin
    in_idle      = (state == IDLE);
    in_wait_opnd = (state == WAIT_OPND);
    op_legal     = (br_op <= 3'd5);
    resolve      = (in_idle & br_valid & op_legal & opnd_ready) | (in_wait_opnd & opnd_ready);
    cur_target   = in_idle ? br_target : held_target;
    cmp_op       = resetn ? (in_idle ? br_op : held_op) : 3'd0;
    // The branch leaves ID on its resolve cycle, so only unresolved operands hold it.
    id_stall     = resetn & ~flush &
                   ((in_idle & br_valid & op_legal & ~opnd_ready) | (in_wait_opnd & ~opnd_ready));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      held_op        <= 3'd0;
      held_target    <= 32'd0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
      illegal_op     <= 1'b0;
      branch_cnt     <= '0;
      taken_cnt      <= '0;
    end else begin
      redirect_valid <= 1'b0;
      illegal_op     <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else if (resolve) begin
        branch_cnt <= branch_cnt + CNT_W'(1);
        if (in_idle) begin
          held_op <= br_op;
        end
        if (cmp_result) begin
          taken_cnt <= taken_cnt + CNT_W'(1);
          if (ds_valid) begin
            redirect_valid <= 1'b1;
            redirect_pc    <= cur_target;
            state          <= IDLE;
          end else begin
            held_target <= cur_target;
            state       <= WAIT_DS;
          end
        end else begin
          state <= IDLE;
        end
      end else begin
        case (state)
          IDLE: begin
            if (br_valid && !op_legal) begin
              illegal_op <= 1'b1;
            end else if (br_valid) begin
              held_op     <= br_op;
              held_target <= br_target;
              state       <= WAIT_OPND;
            end
          end
          WAIT_OPND: state <= WAIT_OPND;
          WAIT_DS: begin
            if (ds_valid) begin
              redirect_valid <= 1'b1;
              redirect_pc    <= held_target;
              state          <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb/tb_branch_resolve_ctrl.sv - directed self-checking bench for branch_resolve_ctrl
module tb_branch_resolve_ctrl;

  logic        clk;
  logic        resetn;
  logic        br_valid;
  logic [2:0]  br_op;
  logic [31:0] br_target;
  logic        opnd_ready;
  logic        ds_valid;
  logic        flush;
  logic        cmp_result;
  logic [2:0]  cmp_op;
  logic        id_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        illegal_op;
  logic [3:0]  branch_cnt;
  logic [3:0]  taken_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  branch_resolve_ctrl #(.CNT_W(4)) dut (
    .clk(clk), .resetn(resetn), .br_valid(br_valid), .br_op(br_op), .br_target(br_target),
    .opnd_ready(opnd_ready), .ds_valid(ds_valid), .flush(flush), .cmp_result(cmp_result),
    .cmp_op(cmp_op), .id_stall(id_stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .illegal_op(illegal_op), .branch_cnt(branch_cnt),
    .taken_cnt(taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    br_valid = 0; br_op = 0; br_target = 0; opnd_ready = 1;
    ds_valid = 1; flush = 0; cmp_result = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_stall"}, {31'd0, id_stall}, 0);
    chk({tag, "_cmp_op"}, {29'd0, cmp_op}, 0);
    chk({tag, "_rv"}, {31'd0, redirect_valid}, 0);
    chk({tag, "_rpc"}, redirect_pc, 0);
    chk({tag, "_ill"}, {31'd0, illegal_op}, 0);
    chk({tag, "_bcnt"}, {28'd0, branch_cnt}, 0);
    chk({tag, "_tcnt"}, {28'd0, taken_cnt}, 0);
  endtask

  initial begin
    idle_inputs();
    resetn = 0;
    br_valid = 1; br_op = 3;
    #12;
    chk_reset_outputs("reset");
    resetn = 1;
    idle_inputs();
    tick();

    // BEQ taken, operands and delay slot ready
    br_valid = 1; br_op = 0; br_target = 32'hBFC0_0100; cmp_result = 1;
    #1;
    chk("beq_stall", {31'd0, id_stall}, 0);
    chk("beq_cmp_op", {29'd0, cmp_op}, 0);
    tick();
    br_valid = 0;
    chk("beq_rv", {31'd0, redirect_valid}, 1);
    chk("beq_rpc", redirect_pc, 32'hBFC0_0100);
    chk("beq_bcnt", {28'd0, branch_cnt}, 1);
    chk("beq_tcnt", {28'd0, taken_cnt}, 1);
    chk("beq_stall2", {31'd0, id_stall}, 0);
    tick();
    chk("beq_rv_off", {31'd0, redirect_valid}, 0);
    chk("beq_rpc_hold", redirect_pc, 32'hBFC0_0100);

    // BNE with operands late for 3 cycles; ID inputs change while waiting
    br_valid = 1; br_op = 1; br_target = 32'h0000_1000; opnd_ready = 0; cmp_result = 1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bne_stall%0d", i), {31'd0, id_stall}, 1);
      chk($sformatf("bne_cmp_op%0d", i), {29'd0, cmp_op}, 1);
      tick();
      br_op = 0; br_target = 32'h0000_2000;
      #1;
    end
    opnd_ready = 1;
    #1;
    chk("bne_cmp_op_res", {29'd0, cmp_op}, 1);
    tick();
    br_valid = 0;
    chk("bne_rv", {31'd0, redirect_valid}, 1);
    chk("bne_rpc", redirect_pc, 32'h0000_1000);
    chk("bne_bcnt", {28'd0, branch_cnt}, 2);
    chk("bne_tcnt", {28'd0, taken_cnt}, 2);

    // BGTZ taken with delay slot missing for 4 cycles
    br_valid = 1; br_op = 3; br_target = 32'h0000_3000; ds_valid = 0; cmp_result = 1;
    tick();
    br_valid = 0; br_op = 0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bgtz_rv%0d", i), {31'd0, redirect_valid}, 0);
      chk($sformatf("bgtz_stall%0d", i), {31'd0, id_stall}, 0);
      chk($sformatf("bgtz_cmp_op%0d", i), {29'd0, cmp_op}, 3);
      tick();
    end
    chk("bgtz_cnt", {24'd0, branch_cnt, taken_cnt}, 32'h33);
    ds_valid = 1;
    tick();
    chk("bgtz_rv", {31'd0, redirect_valid}, 1);
    chk("bgtz_rpc", redirect_pc, 32'h0000_3000);
    tick();
    chk("bgtz_rv_off", {31'd0, redirect_valid}, 0);

    // Illegal op with unknown comparator result
    br_valid = 1; br_op = 6; br_target = 32'h0000_6666; cmp_result = 1'bx;
    #1;
    chk("ill_stall", {31'd0, id_stall}, 0);
    tick();
    br_valid = 0; br_op = 0; cmp_result = 0;
    chk("ill_strobe", {31'd0, illegal_op}, 1);
    chk("ill_rv", {31'd0, redirect_valid}, 0);
    chk("ill_cnt", {24'd0, branch_cnt, taken_cnt}, 32'h33);
    chk("ill_noX", {31'd0, $isunknown({cmp_op, id_stall, redirect_valid, redirect_pc,
                                       illegal_op, branch_cnt, taken_cnt})}, 0);
    tick();
    chk("ill_strobe_off", {31'd0, illegal_op}, 0);

    // BLEZ not taken
    br_valid = 1; br_op = 4; br_target = 32'h0000_4000; cmp_result = 0;
    tick();
    br_valid = 0;
    chk("blez_rv", {31'd0, redirect_valid}, 0);
    chk("blez_cnt", {24'd0, branch_cnt, taken_cnt}, 32'h43);

    // Flush in the resolve cycle of a taken BLTZ
    br_valid = 1; br_op = 5; br_target = 32'h0000_5500; cmp_result = 1; flush = 1;
    tick();
    br_valid = 0; flush = 0;
    chk("fl1_rv", {31'd0, redirect_valid}, 0);
    chk("fl1_cnt", {24'd0, branch_cnt, taken_cnt}, 32'h43);

    // Flush during WAIT_DS
    br_valid = 1; br_op = 0; br_target = 32'h0000_7700; cmp_result = 1; ds_valid = 0;
    tick();
    br_valid = 0;
    flush = 1; ds_valid = 1;
    tick();
    flush = 0; br_op = 2;
    #1;
    chk("fl2_rv", {31'd0, redirect_valid}, 0);
    chk("fl2_idle", {29'd0, cmp_op}, 2);
    chk("fl2_cnt", {24'd0, branch_cnt, taken_cnt}, 32'h54);
    tick();
    chk("fl2_rv_late", {31'd0, redirect_valid}, 0);

    // Next branch after flushes resolves normally
    br_valid = 1; br_op = 2; br_target = 32'h0000_8800; cmp_result = 1;
    tick();
    br_valid = 0;
    chk("post_rv", {31'd0, redirect_valid}, 1);
    chk("post_rpc", redirect_pc, 32'h0000_8800);
    chk("post_cnt", {24'd0, branch_cnt, taken_cnt}, 32'h65);

    // Fresh reset, then 17 back-to-back taken branches wrap the 4-bit counters
    resetn = 0;
    #2;
    resetn = 1;
    idle_inputs();
    br_valid = 1; br_op = 0; cmp_result = 1;
    for (int i = 0; i < 17; i++) begin
      br_target = 32'h0001_0000 + 32'(i * 4);
      tick();
      chk($sformatf("b2b_rv%0d", i), {31'd0, redirect_valid}, 1);
    end
    br_valid = 0;
    chk("wrap_rpc", redirect_pc, 32'h0001_0040);
    chk("wrap_bcnt", {28'd0, branch_cnt}, 1);
    chk("wrap_tcnt", {28'd0, taken_cnt}, 1);

    // Asynchronous reset in the middle of WAIT_OPND
    br_valid = 1; br_op = 1; br_target = 32'h0000_9900; opnd_ready = 0;
    tick();
    br_valid = 0;
    chk("mid_stall", {31'd0, id_stall}, 1);
    #2;
    resetn = 0;
    #1;
    chk_reset_outputs("async");
    resetn = 1;
    #1;
    chk("async_idle", {31'd0, id_stall}, 0);
    tick();
    chk("async_idle2", {31'd0, id_stall}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
